tm_engine: RTL and testbench
============================

Name: tm_engine

Overview:
- Programmable Turing-machine engine: parametrised successor of the fixed-rule busy-beaver blocks.
- The rule table is loaded at runtime through a config write port, so any (NSTATES, NSYMS) machine runs without resynthesis.
- Adds a hardware tape clear, tape-edge detection instead of silent wrap, a step limit, abort, and a live σ (non-zero cell) count.
- Sits beside the max7219 display path; `steps` and `sigma` feed display_value muxing in main.

Parameters:
- NSTATES, 2, number of machine states (≥2).
- NSYMS, 5, number of tape symbols (≥2); symbol 0 is blank.
- TAPE_BITS, 8, tape depth is 2**TAPE_BITS cells.
- CNT_W, 64, width of the step counter and max_steps.
- Derived: QW=$clog2(NSTATES), SW=$clog2(NSYMS), RW=1+QW+1+SW.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  rule-table write strobe; honoured only when busy=0.
- cfg_addr  in  $clog2(NSTATES*NSYMS)  rule index = state*NSYMS + sym.
- cfg_data  in  RW  {halt, next[QW], dir(1=R), wsym[SW]}.
- max_steps  in  CNT_W  step limit; 0 = unlimited. Sampled at start.
- start  in  1  one-cycle pulse; ignored when busy=1.
- abort  in  1  one-cycle pulse; stops a run.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  high in DONE until the next accepted start.
- status  out  2  0=HALT, 1=EDGE, 2=LIMIT, 3=ABORT; valid while done=1.
- steps  out  CNT_W  transitions executed.
- sigma  out  TAPE_BITS+1  count of non-zero cells.
- pos  out  TAPE_BITS  head position.
- state  out  QW  current machine state.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE.
  - busy, done, status, steps, sigma, state = 0.
  - pos = 2**(TAPE_BITS-1).
  - Rule table and tape contents are not reset.
- FSM IDLE -> CLEAR on an accepted start:
  - Latch max_steps.
  - Clear steps and sigma; set state=0.
  - Clear sweeps the address counter 0..2**TAPE_BITS-1, writing 0, one cell per cycle, so CLEAR lasts 2**TAPE_BITS cycles.
- CLEAR -> RUN:
  - pos = 2**(TAPE_BITS-1), state = 0.
- RUN, one transition per cycle:
  - Tape is distributed RAM with asynchronous read and synchronous write.
  - rule = table[state*NSYMS + tape[pos]]; write wsym at pos; steps+1.
  - sigma +1 if old==0 && wsym!=0; −1 if old!=0 && wsym==0; otherwise unchanged.
  - Non-halt rule: state <= next; pos ±1 per dir.
  - Halt rule: writes wsym and counts the step (BB convention); pos and state are held; -> DONE with status HALT.
  - Edge: a move below 0 or above 2**TAPE_BITS-1 still performs the write and counts the step, holds pos, and goes -> DONE with status EDGE.
  - Limit: if max_steps!=0 and the post-increment steps == max_steps, go -> DONE with status LIMIT.
  - Priority on the same step: HALT > EDGE > LIMIT.
  - Symbol read ≥ NSYMS (corrupt tape) is treated as a halt with status EDGE.
- Abort in CLEAR or RUN:
  - Next cycle is DONE with status ABORT; no tape write or step that cycle.
  - Abort has priority over all same-cycle stop conditions.
  - Abort in IDLE or DONE is ignored.
- DONE:
  - Outputs hold; done=1.
  - Accepted start -> CLEAR (done drops the same edge).
- Config:
  - cfg_we while busy=1 is dropped.
  - A cfg write and a start in the same IDLE/DONE cycle: the write lands first, so the run uses the new rule.
- Counters:
  - steps saturates at all-ones and never wraps.
  - sigma cannot exceed 2**TAPE_BITS.

Decomposition:
- Package tm_pkg: status enum (ST_HALT, ST_EDGE, ST_LIMIT, ST_ABORT), FSM enum (IDLE, CLEAR, RUN, DONE), dir constants L=0/R=1, and a rule-struct pack/unpack function parametrised by QW/SW.
- One sub-module, tm_tape_ram: async-read, sync-write, 2**TAPE_BITS × SW.
- The rule table is a flat register array inside tm_engine.

Test Plan:
- BB(2,2), NSYMS=2 instance, program 1RB 1LB / 1LA 1RH, start: done after 256 CLEAR cycles + 6 RUN cycles; status=HALT, steps=6, sigma=4.
- BB(2,3) on default params, program 1RB 2LB 1RH / 2LA 2RB 1LB, unused symbols halt: status=HALT, steps=38, sigma=9.
- TAPE_BITS=8, rule A0=1RA, max_steps=0: status=EDGE, steps=128, sigma=128, pos=255.
- Same machine with max_steps=10: status=LIMIT, steps=10, sigma=10, pos=138. Then max_steps=128: EDGE wins over LIMIT.
- Abort pulsed mid-CLEAR and mid-RUN (step 3 of BB(2,2)): next cycle done=1, status=ABORT, steps frozen (3 for the RUN case).
- Back-to-back starts, plus cfg_we and start while busy: second run gives identical BB(2,2) results, proving the tape was cleared. Mid-run rst_n low asynchronously forces busy=0, done=0, steps=0.

Source files
------------

// File: rtl/tm_pkg.sv
// tm_pkg -- shared types and helpers for the programmable Turing-machine engine.
//
// Contents:
//   status_t  : stop reason reported while done=1 (HALT, EDGE, LIMIT, ABORT)
//   fsm_t     : engine sequencing states (IDLE, CLEAR, RUN, DONE)
//   DIR_L/R   : head-move direction encoding inside a rule word
//   rule_t    : decoded rule with fixed-width fields wide enough for any
//               practical machine; the live widths are QW/SW of the instance
//   pack_rule / unpack_rule : convert between rule_t and the packed
//               {halt, next[QW], dir, wsym[SW]} word used by the config port

package tm_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_EDGE  = 2'd1,
    ST_LIMIT = 2'd2,
    ST_ABORT = 2'd3
  } status_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } fsm_t;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  // Field width of the decoded rule; instances use only the low QW/SW bits.
  localparam int FIELD_W = 8;

  typedef struct packed {
    logic               halt;
    logic [FIELD_W-1:0] next;
    logic               dir;
    logic [FIELD_W-1:0] wsym;
  } rule_t;

  // Packed layout, LSB first: wsym[SW], dir, next[QW], halt.
  function automatic logic [31:0] pack_rule(input rule_t r, input int qw, input int sw);
    logic [31:0] q_mask;
    logic [31:0] s_mask;
    q_mask = (32'd1 << qw) - 32'd1;
    s_mask = (32'd1 << sw) - 32'd1;
    return (32'(r.wsym) & s_mask)
         | (32'(r.dir) << sw)
         | ((32'(r.next) & q_mask) << (sw + 1))
         | (32'(r.halt) << (qw + sw + 1));
  endfunction

  function automatic rule_t unpack_rule(input logic [31:0] raw, input int qw, input int sw);
    rule_t r;
    logic [31:0] q_mask;
    logic [31:0] s_mask;
    q_mask = (32'd1 << qw) - 32'd1;
    s_mask = (32'd1 << sw) - 32'd1;
    r.wsym = FIELD_W'(raw & s_mask);
    r.dir  = |((raw >> sw) & 32'd1);
    r.next = FIELD_W'((raw >> (sw + 1)) & q_mask);
    r.halt = |((raw >> (qw + sw + 1)) & 32'd1);
    return r;
  endfunction

endpackage

// File: rtl/tm_tape_ram.sv
// tm_tape_ram -- tape storage for tm_engine.
//
// Distributed-RAM style memory: combinational read, write on the rising
// clock edge. Contents are deliberately not reset; the engine clears the
// tape itself before every run.
//
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write symbol
//   raddr  in  read address (head position)
//   rdata  out symbol at raddr, same cycle

module tm_tape_ram
  import tm_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tm_engine.sv
// tm_engine -- programmable Turing-machine engine.
//
// The rule table is written at runtime through the cfg port, so any
// (NSTATES, NSYMS) machine can run without resynthesis. A run clears the
// whole tape (one cell per cycle), then executes one transition per cycle
// until the machine halts, walks off the tape, reaches max_steps, or is
// aborted. steps and sigma (non-zero cell count) are live outputs.
//
// Ports:
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   cfg_we     in  rule write strobe, ignored while busy
//   cfg_addr   in  rule index = state*NSYMS + sym
//   cfg_data   in  rule word {halt, next[QW], dir(1=R), wsym[SW]}
//   max_steps  in  step limit, 0 = unlimited; captured when a run starts
//   start      in  start pulse, ignored while busy
//   abort      in  abort pulse, effective in CLEAR and RUN only
//   busy       out high in CLEAR and RUN
//   done       out high in DONE
//   status     out stop reason (0=HALT 1=EDGE 2=LIMIT 3=ABORT), valid with done
//   steps      out transitions executed (saturating)
//   sigma      out number of non-zero tape cells
//   pos        out head position
//   state      out current machine state

module tm_engine
  import tm_pkg::*;
#(
  parameter int NSTATES   = 2,
  parameter int NSYMS     = 5,
  parameter int TAPE_BITS = 8,
  parameter int CNT_W     = 64
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             cfg_we,
  input  logic [$clog2(NSTATES*NSYMS)-1:0]                 cfg_addr,
  input  logic [$clog2(NSTATES)+$clog2(NSYMS)+1:0]         cfg_data,
  input  logic [CNT_W-1:0]                                 max_steps,
  input  logic                                             start,
  input  logic                                             abort,
  output logic                                             busy,
  output logic                                             done,
  output logic [1:0]                                       status,
  output logic [CNT_W-1:0]                                 steps,
  output logic [TAPE_BITS:0]                               sigma,
  output logic [TAPE_BITS-1:0]                             pos,
  output logic [$clog2(NSTATES)-1:0]                       state
);

  localparam int QW     = $clog2(NSTATES);
  localparam int SW     = $clog2(NSYMS);
  localparam int RW     = 1 + QW + 1 + SW;
  localparam int AW     = $clog2(NSTATES * NSYMS);
  localparam int NRULES = NSTATES * NSYMS;
  localparam int DEPTH  = 2 ** TAPE_BITS;

  localparam logic [TAPE_BITS-1:0] POS_MID    = TAPE_BITS'(DEPTH / 2);
  localparam logic [TAPE_BITS-1:0] POS_MAX    = {TAPE_BITS{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [TAPE_BITS:0]   SIGMA_MAX  = (TAPE_BITS + 1)'(DEPTH);
  localparam logic [SW:0]          NSYMS_W    = (SW + 1)'(NSYMS);
  localparam logic [QW:0]          NSTATES_W  = (QW + 1)'(NSTATES);
  localparam logic [AW:0]          NRULES_W   = (AW + 1)'(NRULES);

  fsm_t                 fsm_q,    fsm_d;
  status_t              status_q, status_d;
  logic [TAPE_BITS-1:0] clr_q,    clr_d;
  logic [TAPE_BITS-1:0] pos_q,    pos_d;
  logic [QW-1:0]        state_q,  state_d;
  logic [CNT_W-1:0]     steps_q,  steps_d;
  logic [CNT_W-1:0]     limit_q,  limit_d;
  logic [TAPE_BITS:0]   sigma_q,  sigma_d;

  logic                 tape_we;
  logic [TAPE_BITS-1:0] tape_waddr;
  logic [SW-1:0]        tape_wdata;
  logic [SW-1:0]        tape_rdata;

  logic [RW-1:0]        rule_tbl [NRULES];
  logic [AW-1:0]        rule_idx;
  logic [RW-1:0]        rule_raw;
  rule_t                rule_f;
  logic [SW-1:0]        wsym;
  logic [QW-1:0]        next_state;
  logic                 corrupt;
  logic                 move_edge;
  logic [CNT_W-1:0]     steps_inc;
  logic                 limit_hit;

  assign busy = (fsm_q == CLEAR) || (fsm_q == RUN);

  // Rule writes are dropped during a run so a running machine never sees a
  // half-updated program; out-of-range indices are ignored as well.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy && ({1'b0, cfg_addr} < NRULES_W)) begin
      rule_tbl[cfg_addr] <= cfg_data;
    end
  end

  tm_tape_ram #(
    .ADDR_W (TAPE_BITS),
    .DATA_W (SW)
  ) u_tape (
    .clk   (clk),
    .we    (tape_we),
    .waddr (tape_waddr),
    .wdata (tape_wdata),
    .raddr (pos_q),
    .rdata (tape_rdata)
  );

  // A symbol outside the alphabet (or a state outside the machine, possible
  // when a rule names one) has no rule entry, so the run stops there.
  assign corrupt    = ({1'b0, tape_rdata} >= NSYMS_W) || ({1'b0, state_q} >= NSTATES_W);
  assign rule_idx   = AW'(32'(state_q) * 32'(NSYMS) + 32'(tape_rdata));
  assign rule_raw   = rule_tbl[rule_idx];
  assign rule_f     = unpack_rule(32'(rule_raw), QW, SW);
  assign wsym       = SW'(rule_f.wsym);
  assign next_state = QW'(rule_f.next);

  assign move_edge  = (rule_f.dir == DIR_R) ? (pos_q == POS_MAX) : (pos_q == '0);
  assign steps_inc  = (steps_q == CNT_MAX) ? steps_q : steps_q + 1'b1;
  assign limit_hit  = (limit_q != '0) && (steps_inc == limit_q);

  // Next-state and tape-port logic. Stop priority inside RUN is
  // abort > corrupt > halt > edge > limit; a halting or edge step still
  // writes its symbol and counts, but leaves pos and state alone.
  always_comb begin
    fsm_d      = fsm_q;
    status_d   = status_q;
    clr_d      = clr_q;
    pos_d      = pos_q;
    state_d    = state_q;
    steps_d    = steps_q;
    limit_d    = limit_q;
    sigma_d    = sigma_q;
    tape_we    = 1'b0;
    tape_waddr = pos_q;
    tape_wdata = wsym;

    case (fsm_q)
      IDLE, DONE: begin
        if (start) begin
          fsm_d   = CLEAR;
          clr_d   = '0;
          limit_d = max_steps;
          steps_d = '0;
          sigma_d = '0;
          state_d = '0;
        end
      end

      CLEAR: begin
        if (abort) begin
          fsm_d    = DONE;
          status_d = ST_ABORT;
        end else begin
          tape_we    = 1'b1;
          tape_waddr = clr_q;
          tape_wdata = '0;
          clr_d      = clr_q + 1'b1;
          if (clr_q == POS_MAX) begin
            fsm_d   = RUN;
            pos_d   = POS_MID;
            state_d = '0;
          end
        end
      end

      RUN: begin
        if (abort) begin
          fsm_d    = DONE;
          status_d = ST_ABORT;
        end else if (corrupt) begin
          fsm_d    = DONE;
          status_d = ST_EDGE;
        end else begin
          tape_we = 1'b1;
          steps_d = steps_inc;
          if ((tape_rdata == '0) && (wsym != '0) && (sigma_q != SIGMA_MAX)) begin
            sigma_d = sigma_q + 1'b1;
          end else if ((tape_rdata != '0) && (wsym == '0) && (sigma_q != '0)) begin
            sigma_d = sigma_q - 1'b1;
          end
          if (rule_f.halt) begin
            fsm_d    = DONE;
            status_d = ST_HALT;
          end else if (move_edge) begin
            fsm_d    = DONE;
            status_d = ST_EDGE;
          end else begin
            pos_d   = (rule_f.dir == DIR_R) ? pos_q + 1'b1 : pos_q - 1'b1;
            state_d = next_state;
            if (limit_hit) begin
              fsm_d    = DONE;
              status_d = ST_LIMIT;
            end
          end
        end
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      status_q <= ST_HALT;
      clr_q    <= '0;
      pos_q    <= POS_MID;
      state_q  <= '0;
      steps_q  <= '0;
      limit_q  <= '0;
      sigma_q  <= '0;
    end else begin
      fsm_q    <= fsm_d;
      status_q <= status_d;
      clr_q    <= clr_d;
      pos_q    <= pos_d;
      state_q  <= state_d;
      steps_q  <= steps_d;
      limit_q  <= limit_d;
      sigma_q  <= sigma_d;
    end
  end

  assign done   = (fsm_q == DONE);
  assign status = status_q;
  assign steps  = steps_q;
  assign sigma  = sigma_q;
  assign pos    = pos_q;
  assign state  = state_q;

endmodule

// File: tb/tb_tm_engine.sv
// tb_tm_engine -- directed, scoreboarded bench for tm_engine.
//
// Two engines share the stimulus: inst A uses the default parameters
// (2 states, 5 symbols), inst B has NSYMS=2 for BB(2,2). 'sel' chooses
// which instance receives cfg/start/abort and which one is observed.
// Expected run results are queued when a run is launched and popped when
// the observed engine reaches DONE.

module tb_tm_engine;
  import tm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sel;
  logic        cfg_we, start, abort;
  logic [3:0]  cfg_addr;
  logic [5:0]  cfg_data;
  logic [63:0] max_steps;

  logic        busy_a, done_a, busy_b, done_b;
  logic [1:0]  status_a, status_b;
  logic [63:0] steps_a, steps_b;
  logic [8:0]  sigma_a, sigma_b;
  logic [7:0]  pos_a, pos_b;
  logic [0:0]  state_a, state_b;

  logic        o_busy, o_done;
  logic [1:0]  o_status;
  logic [63:0] o_steps;
  logic [8:0]  o_sigma;
  logic [7:0]  o_pos;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [1:0]  status;
    logic [63:0] steps;
    logic [8:0]  sigma;
    logic [7:0]  pos;
    bit          chk_pos;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  tm_engine #(.NSTATES(2), .NSYMS(5), .TAPE_BITS(8), .CNT_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we && !sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .max_steps(max_steps), .start(start && !sel), .abort(abort && !sel),
    .busy(busy_a), .done(done_a), .status(status_a), .steps(steps_a),
    .sigma(sigma_a), .pos(pos_a), .state(state_a)
  );

  tm_engine #(.NSTATES(2), .NSYMS(2), .TAPE_BITS(8), .CNT_W(64)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we && sel), .cfg_addr(cfg_addr[1:0]), .cfg_data(cfg_data[3:0]),
    .max_steps(max_steps), .start(start && sel), .abort(abort && sel),
    .busy(busy_b), .done(done_b), .status(status_b), .steps(steps_b),
    .sigma(sigma_b), .pos(pos_b), .state(state_b)
  );

  assign o_busy   = sel ? busy_b   : busy_a;
  assign o_done   = sel ? done_b   : done_a;
  assign o_status = sel ? status_b : status_a;
  assign o_steps  = sel ? steps_b  : steps_a;
  assign o_sigma  = sel ? sigma_b  : sigma_a;
  assign o_pos    = sel ? pos_b    : pos_a;

  // Rule word written by hand: {halt, next, dir, wsym}, wsym is sw bits wide.
  function automatic logic [5:0] mk(input logic h, input int nx, input logic d, input int w, input int sw);
    logic [5:0] word;
    if (sw == 3) word = {h, nx[0], d, w[2:0]};
    else         word = {2'b00, h, nx[0], d, w[0]};
    return word;
  endfunction

  function automatic exp_t mk_exp(input string tag, input int st, input int stp,
                                  input int sig, input int p, input bit chk);
    exp_t e;
    e.tag = tag; e.status = 2'(st); e.steps = 64'(stp);
    e.sigma = 9'(sig); e.pos = 8'(p); e.chk_pos = chk;
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic s, input int addr, input logic [5:0] word);
    sel = s; cfg_addr = 4'(addr); cfg_data = word; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic apply_stimulus(input logic s, input logic [63:0] mx, input exp_t e);
    exp_q.push_back(e);
    sel = s; max_steps = mx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (!o_done && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_output();
    exp_t e;
    check_eq("scoreboard_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq({e.tag, ".done"},   64'(o_done),   64'd1);
      check_eq({e.tag, ".busy"},   64'(o_busy),   64'd0);
      check_eq({e.tag, ".status"}, 64'(o_status), 64'(e.status));
      check_eq({e.tag, ".steps"},  o_steps,       e.steps);
      check_eq({e.tag, ".sigma"},  64'(o_sigma),  64'(e.sigma));
      if (e.chk_pos) check_eq({e.tag, ".pos"}, 64'(o_pos), 64'(e.pos));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    sel = 1'b0; cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_addr = '0; cfg_data = '0; max_steps = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values on both instances
    check_eq("rst.busy_a",   64'(busy_a),   0);
    check_eq("rst.done_a",   64'(done_a),   0);
    check_eq("rst.status_a", 64'(status_a), 0);
    check_eq("rst.steps_a",  steps_a,       0);
    check_eq("rst.sigma_a",  64'(sigma_a),  0);
    check_eq("rst.pos_a",    64'(pos_a),    128);
    check_eq("rst.state_a",  64'(state_a),  0);
    check_eq("rst.done_b",   64'(done_b),   0);
    check_eq("rst.pos_b",    64'(pos_b),    128);
    rst_n = 1'b1;
    @(negedge clk);

    // BB(2,2): 1RB 1LB / 1LA 1RH on the NSYMS=2 instance
    cfg_write(1'b1, 0, mk(1'b0, 1, 1'b1, 1, 1));
    cfg_write(1'b1, 1, mk(1'b0, 1, 1'b0, 1, 1));
    cfg_write(1'b1, 2, mk(1'b0, 0, 1'b0, 1, 1));
    cfg_write(1'b1, 3, mk(1'b1, 0, 1'b1, 1, 1));

    apply_stimulus(1'b1, 64'd0, mk_exp("bb22", 0, 6, 4, 0, 0));
    wait_done(2000, cyc);
    check_eq("bb22.cycles", 64'(cyc), 64'd262);
    check_output();

    // Second run with a cfg write and a start attempted while busy
    apply_stimulus(1'b1, 64'd0, mk_exp("bb22_busy_poke", 0, 6, 4, 0, 0));
    repeat (20) @(negedge clk);
    cfg_write(1'b1, 0, mk(1'b1, 0, 1'b1, 0, 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000, cyc);
    check_output();

    // Abort on RUN step 3: three steps done, sigma 2, head at 127
    apply_stimulus(1'b1, 64'd0, mk_exp("abort_run", 3, 3, 2, 127, 1));
    repeat (259) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output();
    @(negedge clk);
    check_eq("abort_run.hold_steps", o_steps, 64'd3);

    // Dirty tape from the aborted run must be cleared by the next one
    apply_stimulus(1'b1, 64'd0, mk_exp("bb22_after_abort", 0, 6, 4, 0, 0));
    wait_done(2000, cyc);
    check_eq("bb22_after_abort.cycles", 64'(cyc), 64'd262);
    check_output();

    // Abort during CLEAR
    apply_stimulus(1'b1, 64'd0, mk_exp("abort_clear", 3, 0, 0, 0, 0));
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output();

    // BB(2,3): 1RB 2LB 1RH / 2LA 2RB 1LB, symbols 3 and 4 halt
    cfg_write(1'b0, 0, mk(1'b0, 1, 1'b1, 1, 3));
    cfg_write(1'b0, 1, mk(1'b0, 1, 1'b0, 2, 3));
    cfg_write(1'b0, 2, mk(1'b1, 0, 1'b1, 1, 3));
    cfg_write(1'b0, 3, mk(1'b1, 0, 1'b1, 0, 3));
    cfg_write(1'b0, 4, mk(1'b1, 0, 1'b1, 0, 3));
    cfg_write(1'b0, 5, mk(1'b0, 0, 1'b0, 2, 3));
    cfg_write(1'b0, 6, mk(1'b0, 1, 1'b1, 2, 3));
    cfg_write(1'b0, 7, mk(1'b0, 1, 1'b0, 1, 3));
    cfg_write(1'b0, 8, mk(1'b1, 0, 1'b1, 0, 3));
    cfg_write(1'b0, 9, mk(1'b1, 0, 1'b1, 0, 3));
    apply_stimulus(1'b0, 64'd0, mk_exp("bb23", 0, 38, 9, 0, 0));
    wait_done(3000, cyc);
    check_output();

    // A0 = 1RA walks right off the tape
    cfg_write(1'b0, 0, mk(1'b0, 0, 1'b1, 1, 3));
    apply_stimulus(1'b0, 64'd0, mk_exp("edge", 1, 128, 128, 255, 1));
    wait_done(3000, cyc);
    check_output();

    apply_stimulus(1'b0, 64'd10, mk_exp("limit", 2, 10, 10, 138, 1));
    wait_done(3000, cyc);
    check_output();

    apply_stimulus(1'b0, 64'd128, mk_exp("edge_over_limit", 1, 128, 128, 255, 1));
    wait_done(3000, cyc);
    check_output();

    // Rule write and start in the same DONE cycle: the new A0 (halt, write 2) is used
    sel = 1'b0; cfg_addr = 4'd0; cfg_data = mk(1'b1, 0, 1'b1, 2, 3); cfg_we = 1'b1;
    exp_q.push_back(mk_exp("cfg_with_start", 0, 1, 1, 128, 1));
    max_steps = 64'd0; start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    wait_done(3000, cyc);
    check_output();

    // Sigma decrement: A0=1RB, B0=1LA, A1=0RH
    cfg_write(1'b0, 0, mk(1'b0, 1, 1'b1, 1, 3));
    cfg_write(1'b0, 5, mk(1'b0, 0, 1'b0, 1, 3));
    cfg_write(1'b0, 1, mk(1'b1, 0, 1'b1, 0, 3));
    apply_stimulus(1'b0, 64'd0, mk_exp("sigma_dec", 0, 3, 1, 128, 1));
    wait_done(3000, cyc);
    check_output();

    // Asynchronous reset in the middle of a long run
    cfg_write(1'b0, 0, mk(1'b0, 0, 1'b1, 1, 3));
    sel = 1'b0; max_steps = 64'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check_eq("midrun.busy_before", 64'(busy_a), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrun_rst.busy",  64'(busy_a), 64'd0);
    check_eq("midrun_rst.done",  64'(done_a), 64'd0);
    check_eq("midrun_rst.steps", steps_a,     64'd0);
    check_eq("midrun_rst.pos",   64'(pos_a),  64'd128);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("after_rst.done", 64'(done_a), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
